seq_detector_param: RTL

- Parametrised serial pattern detector, successor to the fixed 6-bit Mealy detectors in the FSM library.
- Detects an arbitrary SEQ_LEN-bit pattern on a valid-qualified serial bit stream.
- Overlap or non-overlap mode is selected at runtime; a saturating match counter is included.
- Sits between a serial front end and the status/interrupt logic.

---
 rtl/seq_detector_param.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime overlap/non-overlap
// selection, a one-cycle registered match pulse and a saturating match count.
// Optional feature macro: SEQ_DET_PROG_EN adds a runtime-loadable pattern
// register (ports pat_load, pat_in).
module seq_detector_param #(
   parameter int unsigned               SEQ_LEN     = 6,
   parameter logic [SEQ_LEN-1:0]        SEQ_PATTERN = SEQ_LEN'(6'b101101),
   parameter int unsigned               CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic             data_in,
   input  logic             overlap_en,
   input  logic             clr_cnt,
   output logic             seq_dec,
   output logic [CNT_W-1:0] match_cnt
`ifdef SEQ_DET_PROG_EN
   ,
   input  logic               pat_load,
   input  logic [SEQ_LEN-1:0] pat_in
`endif
);

   localparam int unsigned FILL_W = $clog2(SEQ_LEN + 1);

   // Reject pattern lengths the shift/compare datapath is not built for
   generate
      if (SEQ_LEN < 2 || SEQ_LEN > 32) begin : g_bad_len
         $error("seq_detector_param: SEQ_LEN must be in 2..32");
      end
   endgenerate

   logic [SEQ_LEN-1:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               seq_dec_q, seq_dec_d;
   logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
   logic [SEQ_LEN-1:0] pat_c;
   logic [SEQ_LEN-1:0] next_hist_c;
   logic               match_c;
   logic               load_c;

`ifdef SEQ_DET_PROG_EN
   logic [SEQ_LEN-1:0] pat_q, pat_d;

   // Pattern register: reloaded on demand, otherwise held
   always_comb begin
      pat_d = pat_q;
      if (pat_load) begin
         pat_d = pat_in;
      end
   end

   // Pattern register flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q <= SEQ_PATTERN;
      end else begin
         pat_q <= pat_d;
      end
   end

   assign pat_c  = pat_q;
   assign load_c = pat_load;
`else
   assign pat_c  = SEQ_PATTERN;
   assign load_c = 1'b0;
`endif

   // Candidate history and match decision for the bit being offered now
   always_comb begin
      next_hist_c = {hist_q[SEQ_LEN-2:0], data_in};
      match_c     = valid && !load_c && (next_hist_c == pat_c) &&
                    ((32'(fill_q) + 32'd1) >= SEQ_LEN);
   end

   // Next-state: history/fill update, match pulse, saturating counter
   always_comb begin
      hist_d      = hist_q;
      fill_d      = fill_q;
      seq_dec_d   = 1'b0;
      match_cnt_d = match_cnt_q;

      if (load_c) begin
         // a pattern load restarts detection and drops any coincident bit
         hist_d = '0;
         fill_d = '0;
      end else if (valid) begin
         if (match_c && !overlap_en) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = next_hist_c;
            if (fill_q != FILL_W'(SEQ_LEN)) begin
               fill_d = fill_q + FILL_W'(1);
            end
         end
      end

      seq_dec_d = match_c;

      if (clr_cnt) begin
         match_cnt_d = '0;
      end else if (match_c && (match_cnt_q != {CNT_W{1'b1}})) begin
         match_cnt_d = match_cnt_q + CNT_W'(1);
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q      <= '0;
         fill_q      <= '0;
         seq_dec_q   <= 1'b0;
         match_cnt_q <= '0;
      end else begin
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         seq_dec_q   <= seq_dec_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   assign seq_dec   = seq_dec_q;
   assign match_cnt = match_cnt_q;

endmodule
